// File: rtl/puf_resp_capture.sv
// puf_resp_capture: majority-voting, resynchronising capture of WIDTH arbiter PUF outputs
//   iclk/irst_n : clock, asynchronous active-low reset
//   istart      : begin a capture (taken only while ordy)
//   isample     : arbiter outputs settled, sample id now
//   id          : raw arbiter outputs, asynchronous to iclk
//   ordy/obusy  : idle / capture in progress
//   oq/ostable  : voted response and per-bit unanimity flags, held until next result
//   ovalid      : one-cycle pulse when oq/ostable update
module puf_resp_capture #(
  parameter int WIDTH       = 8,
  parameter int REPEATS     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             istart,
  input  logic             isample,
  input  logic [WIDTH-1:0] id,
  output logic             ordy,
  output logic             obusy,
  output logic [WIDTH-1:0] oq,
  output logic [WIDTH-1:0] ostable,
  output logic             ovalid
);
  localparam int CW = $clog2(REPEATS + 1);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_next;
  logic [CW-1:0] issued, counted;
  logic [CW-1:0] ones [WIDTH];
  logic [CW-1:0] ones_next [WIDTH];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_s;
  logic [WIDTH-1:0] q_next, stable_next;
  logic start, strobe_in, strobe, done;
  assign start     = state == IDLE && istart;
  assign strobe_in = state == COLLECT && isample && issued < CW'(REPEATS);
  assign strobe    = sync_s[SYNC_STAGES-1];
  // the final synced strobe is the one arriving while counted is one short of REPEATS
  assign done      = state == COLLECT && strobe && counted == CW'(REPEATS - 1);
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      ones_next[i]   = ones[i] + CW'(strobe && sync_d[SYNC_STAGES-1][i]);
      q_next[i]      = ones_next[i] > CW'(REPEATS / 2);
      stable_next[i] = ones_next[i] == '0 || ones_next[i] == CW'(REPEATS);
    end
  end
  always_ff @(posedge iclk or negedge irst_n)
    if (!irst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (start) state_next = COLLECT;
    else if (done) state_next = IDLE;
  end
  always_comb begin
    ordy  = state == IDLE;
    obusy = state != IDLE;
  end
  // id and the gated strobe travel through identical chains so they stay aligned
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_d[s] <= '0;
      sync_s <= '0;
    end else begin
      sync_d[0] <= id;
      sync_s[0] <= strobe_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[s] <= sync_d[s-1];
        sync_s[s] <= sync_s[s-1];
      end
      if (start) sync_s <= '0;
    end
  end
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      issued  <= '0;
      counted <= '0;
      for (int i = 0; i < WIDTH; i++) ones[i] <= '0;
      oq      <= '0;
      ostable <= '0;
      ovalid  <= 1'b0;
    end else begin
      ovalid <= done;
      if (start) begin
        issued  <= '0;
        counted <= '0;
        for (int i = 0; i < WIDTH; i++) ones[i] <= '0;
      end else if (state == COLLECT) begin
        if (strobe_in) issued <= issued + 1'b1;
        if (strobe) begin
          counted <= counted + 1'b1;
          for (int i = 0; i < WIDTH; i++) ones[i] <= ones_next[i];
        end
      end
      if (done) begin
        oq      <= q_next;
        ostable <= stable_next;
      end
    end
  end
endmodule

// File: tb/tb_puf_resp_capture.sv
// tb_puf_resp_capture: directed self-checking bench for puf_resp_capture (WIDTH=4, REPEATS=5, SYNC_STAGES=2)
module tb_puf_resp_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic sample = 1'b0;
  logic [3:0] d = '0;
  logic rdy, busy, valid;
  logic [3:0] q, stable;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  puf_resp_capture #(.WIDTH(4), .REPEATS(5), .SYNC_STAGES(2)) dut (
    .iclk(clk), .irst_n(rst_n), .istart(start), .isample(sample), .id(d),
    .ordy(rdy), .obusy(busy), .oq(q), .ostable(stable), .ovalid(valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_sample(input logic [3:0] v);
    d = v;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = valid;
    end
  endtask
  task automatic test_reset();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q, stable, valid, rdy, busy} !== 11'b0000_0000_0_1_0) begin
      fails++;
      $display("FAIL reset q=%b stable=%b valid=%b rdy=%b busy=%b exp 0000 0000 0 1 0", q, stable, valid, rdy, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_constant();
    do_start();
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL const_busy rdy=%b busy=%b exp 0 1", rdy, busy);
    end
    for (int k = 0; k < 5; k++) begin
      do_sample(4'b1010);
      if (k < 4) tick();
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL const_early valid=%b exp 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL const_latency valid=%b rdy=%b exp 1 1", valid, rdy);
    end
    checks++;
    if (q !== 4'b1010 || stable !== 4'b1111) begin
      fails++;
      $display("FAIL const_result q=%b stable=%b exp 1010 1111", q, stable);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || q !== 4'b1010) begin
      fails++;
      $display("FAIL const_pulse valid=%b q=%b exp 0 1010", valid, q);
    end
  endtask
  task automatic test_split();
    logic [3:0] v [5];
    bit ok;
    v = '{4'b1101, 4'b1110, 4'b1101, 4'b1100, 4'b1111};
    do_start();
    for (int k = 0; k < 5; k++) begin
      do_sample(v[k]);
      tick();
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL split_timeout valid=%b exp 1", valid);
    end
    checks++;
    if (q !== 4'b1101 || stable !== 4'b1100) begin
      fails++;
      $display("FAIL split_result q=%b stable=%b exp 1101 1100", q, stable);
    end
  endtask
  task automatic test_mid_reset();
    bit ok;
    do_start();
    for (int k = 0; k < 3; k++) begin
      do_sample(4'b1111);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q, stable, valid, rdy} !== 10'b0000_0000_0_1) begin
      fails++;
      $display("FAIL midreset_clear q=%b stable=%b valid=%b rdy=%b exp 0000 0000 0 1", q, stable, valid, rdy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    do_start();
    for (int k = 0; k < 5; k++) begin
      do_sample(4'b0110);
      tick();
    end
    wait_valid(ok);
    checks++;
    if (!ok || q !== 4'b0110 || stable !== 4'b1111) begin
      fails++;
      $display("FAIL midreset_result ok=%0d q=%b stable=%b exp 1 0110 1111", ok, q, stable);
    end
  endtask
  task automatic test_ignored();
    int pulses = 0;
    logic [3:0] got_q = 'x, got_s = 'x;
    bit ok;
    do_start();
    for (int k = 0; k < 3; k++) begin
      do_sample(4'b0011);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ign_start_busy busy=%b exp 1", busy);
    end
    do_sample(4'b0011);
    do_sample(4'b0011);
    do_sample(4'b1100);
    for (int k = 0; k < 12; k++) begin
      if (valid) begin
        pulses++;
        got_q = q;
        got_s = stable;
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL ign_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (got_q !== 4'b0011 || got_s !== 4'b1111) begin
      fails++;
      $display("FAIL ign_result q=%b stable=%b exp 0011 1111", got_q, got_s);
    end
    checks++;
    if (rdy !== 1'b1) begin
      fails++;
      $display("FAIL ign_idle rdy=%b exp 1", rdy);
    end
    start = 1'b1;
    sample = 1'b1;
    d = 4'b1111;
    tick();
    start = 1'b0;
    sample = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_sample(4'b0000);
      tick();
    end
    wait_valid(ok);
    checks++;
    if (!ok || q !== 4'b0000 || stable !== 4'b1111) begin
      fails++;
      $display("FAIL ign_simul ok=%0d q=%b stable=%b exp 1 0000 1111", ok, q, stable);
    end
  endtask
  task automatic test_back_to_back();
    int c0, c1;
    bit ok;
    do_start();
    for (int k = 0; k < 5; k++) do_sample(4'b1001);
    wait_valid(ok);
    c0 = cyc;
    checks++;
    if (!ok || q !== 4'b1001 || stable !== 4'b1111) begin
      fails++;
      $display("FAIL b2b_first ok=%0d q=%b stable=%b exp 1 1001 1111", ok, q, stable);
    end
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart busy=%b exp 1", busy);
    end
    for (int k = 0; k < 5; k++) do_sample(4'b0101);
    wait_valid(ok);
    c1 = cyc;
    checks++;
    if (!ok || q !== 4'b0101 || stable !== 4'b1111) begin
      fails++;
      $display("FAIL b2b_second ok=%0d q=%b stable=%b exp 1 0101 1111", ok, q, stable);
    end
    checks++;
    if (c1 - c0 < 8) begin
      fails++;
      $display("FAIL b2b_spacing got %0d cycles exp >=8", c1 - c0);
    end
  endtask
  initial begin
    test_reset();
    test_constant();
    test_split();
    test_mid_reset();
    test_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
